// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage payloads and the write-back FSM encoding.
package cpu_types_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            reg_wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] wb_data;
  } lsu_wb_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } wb_if_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COMMIT   = 2'd1,
    S_REDIRECT = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/stage_if.sv
// Generic valid/ready handshake between pipeline stages, typed by its payload.
interface stage_if #(
  parameter type payload_t = logic
) ();

  logic     valid;
  logic     ready;
  payload_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/wbu_retire_counter.sv
// Free-running event counter with async reset; wraps modulo 2^CNT_W.
module retire_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: retires one instruction at a time, writes the register file
// and redirects fetch to the next PC. Outputs decode from state and registers only.
module wbu
  import cpu_types_pkg::*;
#(
  parameter int XLEN  = cpu_types_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  stage_if.slave           wbu_in,
  stage_if.master          wbu_out,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_npc,
  output logic [CNT_W-1:0] commit_cnt
);

  wbu_state_e      state, state_nxt;
  lsu_wb_t         in_pl;
  wb_if_t          out_pl;
  logic            accept;
  logic            retire;

  logic            pl_reg_valid;
  logic            pl_reg_wen;
  logic [4:0]      pl_reg_rd_addr;
  logic [XLEN-1:0] pl_reg_pc_target;
  logic [XLEN-1:0] pl_reg_wb_data;

  assign in_pl  = wbu_in.payload;
  assign accept = (state == S_IDLE) && wbu_in.valid;
  assign retire = (state == S_COMMIT) && pl_reg_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pl_reg_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pl_reg_valid <= in_pl.valid;
      end
    end
  end

  // Payload data needs no reset: it is only observed once pl_reg_valid qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      pl_reg_wen       <= in_pl.reg_wen;
      pl_reg_rd_addr   <= in_pl.rd_addr;
      pl_reg_pc_target <= in_pl.pc_target;
      pl_reg_wb_data   <= in_pl.wb_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (wbu_in.valid) state_nxt = S_COMMIT;
      S_COMMIT:   state_nxt = pl_reg_valid ? S_REDIRECT : S_IDLE;
      S_REDIRECT: if (wbu_out.ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign wbu_in.ready = (state == S_IDLE);

  assign rf_wen       = retire && pl_reg_wen && (pl_reg_rd_addr != 5'd0);
  assign rf_waddr     = pl_reg_rd_addr;
  assign rf_wdata     = pl_reg_wb_data;
  assign commit_valid = retire;
  assign commit_npc   = pl_reg_pc_target;

  assign out_pl.valid    = 1'b1;
  assign out_pl.pc       = pl_reg_pc_target;
  assign wbu_out.valid   = (state == S_REDIRECT);
  assign wbu_out.payload = out_pl;

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .cnt   (commit_cnt)
  );

endmodule

// File: tb/tb_wbu.sv
// Directed and randomized checks of wbu against a transaction-level retire model.
module tb_wbu;
  import cpu_types_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             commit_valid;
  logic [31:0]      commit_npc;
  logic [CNT_W-1:0] commit_cnt;

  stage_if #(.payload_t(lsu_wb_t)) in_if ();
  stage_if #(.payload_t(wb_if_t))  out_if ();

  wbu #(
    .XLEN  (32),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbu_in       (in_if),
    .wbu_out      (out_if),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_npc   (commit_npc),
    .commit_cnt   (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] m_cnt    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lsu_wb_t rnd_pl(input bit force_valid);
    lsu_wb_t p;
    p.valid     = force_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
    p.reg_wen   = 1'($urandom_range(0, 1));
    p.rd_addr   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    p.pc_target = $urandom;
    p.wb_data   = $urandom;
    return p;
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (in_if.ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", 64'(in_if.ready), 64'(1'b1));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_ready"},  64'(in_if.ready),   64'(1'b1));
    chk({tag, "_out_valid"}, 64'(out_if.valid),  64'(1'b0));
    chk({tag, "_rf_wen"},    64'(rf_wen),        64'(1'b0));
    chk({tag, "_commit"},    64'(commit_valid),  64'(1'b0));
    chk({tag, "_cnt"},       64'(commit_cnt),    64'(m_cnt));
  endtask

  // One full transaction starting from an idle negedge; stall = cycles of fetch back-pressure.
  task automatic run_txn(input lsu_wb_t p, input int stall);
    lsu_wb_t junk;
    wait_idle();
    out_if.ready   = (stall == 0);
    in_if.payload  = p;
    in_if.valid    = 1'b1;
    @(posedge clk);
    #1;
    junk           = rnd_pl(1'b1);
    in_if.payload  = junk;
    in_if.valid    = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("commit_valid", 64'(commit_valid), 64'(p.valid));
    chk("rf_wen", 64'(rf_wen), 64'(p.valid && p.reg_wen && p.rd_addr != 5'd0));
    chk("commit_cnt_pre", 64'(commit_cnt), 64'(m_cnt));
    chk("busy_in_ready", 64'(in_if.ready), 64'(1'b0));
    chk("commit_out_valid", 64'(out_if.valid), 64'(1'b0));
    if (p.valid) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(p.rd_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(p.wb_data));
      chk("commit_npc", 64'(commit_npc), 64'(p.pc_target));
      m_cnt = m_cnt + 1'b1;
    end
    @(negedge clk);
    if (!p.valid) begin
      in_if.valid = 1'b0;
      check_quiet("bubble");
      return;
    end
    for (int i = 0; i < stall; i++) begin
      chk("stall_out_valid", 64'(out_if.valid), 64'(1'b1));
      chk("stall_out_pc", 64'(out_if.payload.pc), 64'(p.pc_target));
      chk("stall_in_ready", 64'(in_if.ready), 64'(1'b0));
      chk("stall_commit", 64'(commit_valid), 64'(1'b0));
      @(negedge clk);
    end
    out_if.ready = 1'b1;
    chk("redir_out_valid", 64'(out_if.valid), 64'(1'b1));
    chk("redir_pl_valid", 64'(out_if.payload.valid), 64'(1'b1));
    chk("redir_out_pc", 64'(out_if.payload.pc), 64'(p.pc_target));
    chk("redir_cnt", 64'(commit_cnt), 64'(m_cnt));
    chk("redir_rf_wen", 64'(rf_wen), 64'(1'b0));
    in_if.valid = 1'b0;
    @(negedge clk);
    check_quiet("post");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_cnt = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    lsu_wb_t p;
    rst_n         = 1'b0;
    in_if.valid   = 1'b0;
    in_if.payload = '0;
    out_if.ready  = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("por");
    rst_n = 1'b1;
    @(negedge clk);

    p = lsu_wb_t'{valid: 1'b1, reg_wen: 1'b1, rd_addr: 5'd5,
                  pc_target: 32'h8000_0004, wb_data: 32'hDEAD_BEEF};
    run_txn(p, 0);
    chk("alu_cnt", 64'(commit_cnt), 64'(4'd1));

    p = lsu_wb_t'{valid: 1'b1, reg_wen: 1'b1, rd_addr: 5'd0,
                  pc_target: 32'h8000_0008, wb_data: 32'h0000_1234};
    run_txn(p, 0);
    chk("x0_cnt", 64'(commit_cnt), 64'(4'd2));

    p = lsu_wb_t'{valid: 1'b0, reg_wen: 1'b1, rd_addr: 5'd7,
                  pc_target: 32'h8000_000C, wb_data: 32'h5555_AAAA};
    run_txn(p, 0);

    run_txn(rnd_pl(1'b1), 10);
    run_txn(rnd_pl(1'b1), 0);

    // Async reset between edges while redirecting.
    p = rnd_pl(1'b1);
    wait_idle();
    out_if.ready = 1'b0;
    in_if.payload = p;
    in_if.valid = 1'b1;
    @(posedge clk);
    #1 in_if.valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_out_valid", 64'(out_if.valid), 64'(1'b1));
    #3 rst_n = 1'b0;
    m_cnt = '0;
    #1;
    check_quiet("rst_redirect");
    @(negedge clk);
    rst_n = 1'b1;
    out_if.ready = 1'b1;
    p = rnd_pl(1'b1);
    p.reg_wen = 1'b0;
    run_txn(p, 0);

    // Async reset during the commit cycle suppresses the write and retire.
    p = rnd_pl(1'b1);
    p.reg_wen = 1'b1;
    p.rd_addr = 5'd9;
    wait_idle();
    in_if.payload = p;
    in_if.valid = 1'b1;
    @(posedge clk);
    #1 in_if.valid = 1'b0;
    #2 rst_n = 1'b0;
    m_cnt = '0;
    #1;
    check_quiet("rst_commit");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("rst_commit_after");

    for (int i = 0; i < 40; i++) begin
      run_txn(rnd_pl(1'b0), $urandom_range(0, 3));
    end

    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_txn(rnd_pl(1'b1), 0);
    end
    chk("cnt_wrap", 64'(commit_cnt), 64'(4'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
